log_capture_sched: RTL and testbench

// Frame-capture scheduler in front of the PPM frame logger. It watches the live

---
 rtl/log_capture_sched.sv | 180 ++++++++++++++++++
 tb/tb_log_capture_sched.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/log_capture_sched.sv
// Frame-capture scheduler: gates whole video frames from the live stream to the frame logger.
// Optional geometry checker enabled by defining FRAME_CHECK_EN.
module log_capture_sched #(
  parameter int unsigned DW    = 32,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned PIX_W = 20
) (
  input  logic             vga_clk,
  input  logic             vga_rst_n,
  input  logic             vga_vs,
  input  logic             vga_de,
  input  logic [DW-1:0]    vga_data,
  input  logic             cap_start,
  input  logic             cap_abort,
  input  logic [CNT_W-1:0] cap_frames,
  input  logic [CNT_W-1:0] cap_skip,
  input  logic [PIX_W-1:0] exp_pixels,
  output logic             log_vs,
  output logic             log_de,
  output logic [DW-1:0]    log_data,
  output logic             cap_busy,
  output logic             cap_done,
  output logic [CNT_W-1:0] frame_idx,
  output logic             cap_err
);

  localparam int unsigned CW1 = CNT_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_CAPT,
    ST_SKIP,
    ST_DONE
  } state_e;

  state_e           state_q, state_d;
  logic             vs_q;
  logic [CNT_W-1:0] frames_q, frames_d;
  logic [CNT_W-1:0] skip_q, skip_d;
  logic [CNT_W-1:0] skip_cnt_q, skip_cnt_d;
  logic [CNT_W-1:0] frame_idx_q, frame_idx_d;
  logic             log_vs_q, log_vs_d;
  logic             log_de_q, log_de_d;
  logic [DW-1:0]    log_data_q;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             sof_c, eof_c, last_frame_c;

  assign sof_c        = vga_vs & ~vs_q;
  assign eof_c        = ~vga_vs & vs_q;
  assign last_frame_c = (CW1'(frame_idx_q) + CW1'(1)) == CW1'(frames_q);

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    frames_d    = frames_q;
    skip_d      = skip_q;
    skip_cnt_d  = skip_cnt_q;
    frame_idx_d = frame_idx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cap_start) begin
          frames_d    = cap_frames;
          skip_d      = cap_skip;
          frame_idx_d = '0;
          state_d     = (cap_frames == '0) ? ST_DONE : ST_ARM;
        end
      end
      ST_ARM: begin
        if (cap_abort)  state_d = ST_DONE;
        else if (sof_c) state_d = ST_CAPT;
      end
      ST_CAPT: begin
        if (cap_abort) begin
          state_d = ST_DONE;
        end else if (eof_c) begin
          if (frame_idx_q != '1) frame_idx_d = frame_idx_q + CNT_W'(1);
          if (last_frame_c) begin
            state_d = ST_DONE;
          end else if (skip_q == '0) begin
            state_d = ST_ARM;
          end else begin
            skip_cnt_d = skip_q;
            state_d    = ST_SKIP;
          end
        end
      end
      ST_SKIP: begin
        if (cap_abort) begin
          state_d = ST_DONE;
        end else if (eof_c) begin
          skip_cnt_d = skip_cnt_q - CNT_W'(1);
          if (skip_cnt_q == CNT_W'(1)) state_d = ST_ARM;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Gate on the state being entered so abort drops log_vs on the same edge
    log_vs_d = (state_d == ST_CAPT) & vga_vs;
    log_de_d = log_vs_d & vga_de;
    busy_d   = (state_d != ST_IDLE);
    done_d   = (state_q == ST_DONE);
  end

  always_ff @(posedge vga_clk) begin
    if (!vga_rst_n) begin
      state_q     <= ST_IDLE;
      vs_q        <= 1'b0;
      frames_q    <= '0;
      skip_q      <= '0;
      skip_cnt_q  <= '0;
      frame_idx_q <= '0;
      log_vs_q    <= 1'b0;
      log_de_q    <= 1'b0;
      log_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      vs_q        <= vga_vs;
      frames_q    <= frames_d;
      skip_q      <= skip_d;
      skip_cnt_q  <= skip_cnt_d;
      frame_idx_q <= frame_idx_d;
      log_vs_q    <= log_vs_d;
      log_de_q    <= log_de_d;
      log_data_q  <= vga_data;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign log_vs    = log_vs_q;
  assign log_de    = log_de_q;
  assign log_data  = log_data_q;
  assign cap_busy  = busy_q;
  assign cap_done  = done_q;
  assign frame_idx = frame_idx_q;

`ifdef FRAME_CHECK_EN
  logic [PIX_W-1:0] pix_cnt_q, pix_cnt_d;
  logic             err_q, err_d;

  // Count logged pixels per frame; flag a mismatch against the expected size at EOF
  always_comb begin
    pix_cnt_d = pix_cnt_q;
    err_d     = err_q;
    if (sof_c) begin
      pix_cnt_d = log_de_d ? PIX_W'(1) : '0;
    end else if (log_de_d && (pix_cnt_q != '1)) begin
      pix_cnt_d = pix_cnt_q + PIX_W'(1);
    end
    if ((state_q == ST_IDLE) && cap_start) begin
      err_d = 1'b0;
    end else if ((state_q == ST_CAPT) && eof_c && (pix_cnt_q != exp_pixels)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (!vga_rst_n) begin
      pix_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      pix_cnt_q <= pix_cnt_d;
      err_q     <= err_d;
    end
  end

  assign cap_err = err_q;
`else
  logic unused_exp_pixels_c;
  assign unused_exp_pixels_c = ^exp_pixels;
  assign cap_err             = 1'b0;
`endif

endmodule

// File: tb/tb_log_capture_sched.sv
// Scoreboard bench for log_capture_sched: driver queues expected logged pixels,
// a negedge monitor pops and compares them; status outputs are checked directly.
module tb_log_capture_sched;

  localparam int unsigned DW    = 32;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned PIX_W = 20;
  localparam int          VSH   = 2 + 16 * 18;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             vga_vs, vga_de;
  logic [DW-1:0]    vga_data;
  logic             cap_start, cap_abort;
  logic [CNT_W-1:0] cap_frames, cap_skip;
  logic [PIX_W-1:0] exp_pixels;
  logic             log_vs, log_de;
  logic [DW-1:0]    log_data;
  logic             cap_busy, cap_done, cap_err;
  logic [CNT_W-1:0] frame_idx;

  int               checks = 0;
  int               errors = 0;
  int               vs_hi = 0;
  int               done_cnt = 0;
  int               frame_tag = 0;
  logic [DW-1:0]    exp_q[$];

  always #5 clk = ~clk;

  log_capture_sched #(.DW(DW), .CNT_W(CNT_W), .PIX_W(PIX_W)) dut (
    .vga_clk   (clk),
    .vga_rst_n (rst_n),
    .vga_vs    (vga_vs),
    .vga_de    (vga_de),
    .vga_data  (vga_data),
    .cap_start (cap_start),
    .cap_abort (cap_abort),
    .cap_frames(cap_frames),
    .cap_skip  (cap_skip),
    .exp_pixels(exp_pixels),
    .log_vs    (log_vs),
    .log_de    (log_de),
    .log_data  (log_data),
    .cap_busy  (cap_busy),
    .cap_done  (cap_done),
    .frame_idx (frame_idx),
    .cap_err   (cap_err)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: every logged pixel must match the head of the expected queue
  initial begin
    logic [DW-1:0] e;
    forever begin
      @(negedge clk);
      if (log_vs === 1'b1) vs_hi++;
      if (cap_done === 1'b1) done_cnt++;
      if (log_de === 1'b1) begin
        check("log_de_needs_log_vs", 64'(log_vs), 64'(1));
        if (exp_q.size() == 0) begin
          check("unexpected_log_de", 64'(log_data), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("log_data", 64'(log_data), 64'(e));
        end
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      vga_vs = 1'b0; vga_de = 1'b0; cap_start = 1'b0; cap_abort = 1'b0;
    end
  endtask

  task automatic pulse_start(input int frames, input int skip);
    @(posedge clk); #1;
    cap_frames = CNT_W'(frames); cap_skip = CNT_W'(skip); cap_start = 1'b1;
    @(posedge clk); #1;
    cap_start = 1'b0;
  endtask

  // One 16x16 frame (16 lines of 16 de + 2 blank), then 4 cycles of vertical blank
  task automatic drive_frame(input bit logged, input int npix, input int start_at, input int abort_at);
    int p;
    bit live;
    p = 0;
    live = logged;
    frame_tag++;
    for (int c = 0; c < VSH + 4; c++) begin
      @(posedge clk); #1;
      vga_vs    = (c < VSH);
      vga_de    = (c >= 2) && (c < VSH) && (((c - 2) % 18) < 16) && (p < npix);
      cap_start = (c == start_at);
      cap_abort = (c == abort_at);
      if (c == abort_at) live = 1'b0;
      if (vga_de) begin
        vga_data = {8'h5a, 8'(frame_tag), 16'(p)};
        if (live) exp_q.push_back(vga_data);
        p++;
      end
      if (abort_at >= 0) begin
        if (c == abort_at) begin
          @(negedge clk);
          check("abort_vs_before", 64'(log_vs), 64'(1));
        end else if (c == abort_at + 1) begin
          @(negedge clk);
          check("abort_vs_after", 64'(log_vs), 64'(0));
          check("abort_busy", 64'(cap_busy), 64'(1));
        end else if (c == abort_at + 2) begin
          @(negedge clk);
          check("abort_done", 64'(cap_done), 64'(1));
          check("abort_frame_idx", 64'(frame_idx), 64'(1));
        end
      end
    end
  endtask

  initial begin
    int d0;
    int v0;
    rst_n = 1'b0;
    vga_vs = 1'b0; vga_de = 1'b0; vga_data = '0;
    cap_start = 1'b0; cap_abort = 1'b0;
    cap_frames = '0; cap_skip = '0; exp_pixels = PIX_W'(256);

    // T1: reset with live traffic
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      vga_vs = 1'($urandom); vga_de = 1'($urandom); vga_data = $urandom;
      cap_start = 1'(i); cap_frames = 8'd3;
      @(negedge clk);
      check("reset_outputs",
            64'({log_vs, log_de, log_data, cap_busy, cap_done, frame_idx, cap_err}), 64'(0));
    end
    @(posedge clk); #1;
    rst_n = 1'b1; vga_vs = 1'b0; vga_de = 1'b0; cap_start = 1'b0;
    idle(3);

    // T2: start mid-frame, 3 whole frames logged
    d0 = done_cnt;
    cap_frames = 8'd3; cap_skip = 8'd0;
    drive_frame(1'b0, 256, 100, -1);
    drive_frame(1'b1, 256, -1, -1);
    drive_frame(1'b1, 256, -1, -1);
    drive_frame(1'b1, 256, -1, -1);
    drive_frame(1'b0, 256, -1, -1);
    idle(2);
    @(negedge clk);
    check("t2_queue_empty", 64'(exp_q.size()), 64'(0));
    check("t2_frame_idx", 64'(frame_idx), 64'(3));
    check("t2_done_pulses", 64'(done_cnt - d0), 64'(1));
    check("t2_log_vs_low", 64'(log_vs), 64'(0));
    check("t2_busy", 64'(cap_busy), 64'(0));

    // T3: frames=2 skip=2 -> first and fourth frames logged
    d0 = done_cnt;
    pulse_start(2, 2);
    drive_frame(1'b1, 256, -1, -1);
    drive_frame(1'b0, 256, -1, -1);
    drive_frame(1'b0, 256, -1, -1);
    drive_frame(1'b1, 256, -1, -1);
    drive_frame(1'b0, 256, -1, -1);
    idle(2);
    @(negedge clk);
    check("t3_queue_empty", 64'(exp_q.size()), 64'(0));
    check("t3_frame_idx", 64'(frame_idx), 64'(2));
    check("t3_done_pulses", 64'(done_cnt - d0), 64'(1));

    // T4: abort mid frame 2, restart 3 clk later with a single-frame run
    d0 = done_cnt;
    pulse_start(5, 0);
    drive_frame(1'b1, 256, -1, -1);
    cap_frames = 8'd1;
    drive_frame(1'b1, 256, 103, 100);
    @(negedge clk);
    check("t4_restart_idx", 64'(frame_idx), 64'(0));
    check("t4_restart_busy", 64'(cap_busy), 64'(1));
    drive_frame(1'b1, 256, -1, -1);
    idle(2);
    @(negedge clk);
    check("t4_frame_idx", 64'(frame_idx), 64'(1));
    check("t4_busy", 64'(cap_busy), 64'(0));
    check("t4_done_pulses", 64'(done_cnt - d0), 64'(2));
    check("t4_queue_empty", 64'(exp_q.size()), 64'(0));

    // T5a: zero frames -> done two clocks after start, no log_vs
    v0 = vs_hi;
    d0 = done_cnt;
    @(posedge clk); #1;
    cap_frames = 8'd0; cap_start = 1'b1;
    @(posedge clk); #1;
    cap_start = 1'b0;
    @(negedge clk);
    check("t5_done_early", 64'(cap_done), 64'(0));
    check("t5_busy_done_state", 64'(cap_busy), 64'(1));
    @(posedge clk);
    @(negedge clk);
    check("t5_done_pulse", 64'(cap_done), 64'(1));
    check("t5_busy_after", 64'(cap_busy), 64'(0));
    drive_frame(1'b0, 256, -1, -1);
    check("t5_no_log_vs", 64'(vs_hi - v0), 64'(0));
    check("t5_one_done", 64'(done_cnt - d0), 64'(1));

    // T5b: start while busy is ignored
    d0 = done_cnt;
    pulse_start(1, 0);
    cap_frames = 8'd7; cap_skip = 8'd3;
    drive_frame(1'b1, 256, 50, -1);
    drive_frame(1'b0, 256, -1, -1);
    idle(2);
    @(negedge clk);
    check("t5b_frame_idx", 64'(frame_idx), 64'(1));
    check("t5b_done_pulses", 64'(done_cnt - d0), 64'(1));
    check("t5b_queue_empty", 64'(exp_q.size()), 64'(0));

    // T6: short frame against exp_pixels=256
    exp_pixels = PIX_W'(256);
`ifdef FRAME_CHECK_EN
    pulse_start(2, 0);
    drive_frame(1'b1, 255, -1, -1);
    @(negedge clk);
    check("t6_err_set", 64'(cap_err), 64'(1));
    drive_frame(1'b1, 256, -1, -1);
    @(negedge clk);
    check("t6_err_sticky", 64'(cap_err), 64'(1));
    idle(2);
    pulse_start(0, 0);
    idle(3);
    @(negedge clk);
    check("t6_err_cleared", 64'(cap_err), 64'(0));
`else
    pulse_start(1, 0);
    drive_frame(1'b1, 255, -1, -1);
    idle(2);
    @(negedge clk);
    check("t6_err_tied_low", 64'(cap_err), 64'(0));
`endif
    check("final_queue_empty", 64'(exp_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
